// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Holds the PC, fetches from the instruction cache over a req/ready handshake
// and presents ir/pc_out/next_pc/valid to decode. Handles downstream stalls,
// branch redirects and discarding a stale miss when a branch lands mid-miss.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_stall_pc           downstream stall: freeze PC and IF/ID
//   i_branch_taken       one-cycle redirect request
//   i_branch_target      redirect address (bits [1:0] forced to 0)
//   o_icache_req         fetch request (low only while reset is asserted)
//   o_icache_addr        word-aligned fetch address
//   i_icache_ready       cache data valid for o_icache_addr (may be same cycle)
//   i_icache_data        instruction word
//   o_ir, o_pc_out       IF/ID instruction and its address
//   o_next_pc            IF/ID pc_out + 4
//   o_valid              IF/ID holds a real instruction
//   o_fetch_stall        miss in progress (req & ~ready)

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall_pc,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic        o_icache_req,
    output logic [31:0] o_icache_addr,
    input  logic        i_icache_ready,
    input  logic [31:0] i_icache_data,
    output logic [31:0] o_ir,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_next_pc,
    output logic        o_valid,
    output logic        o_fetch_stall
);

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_stale_addr;
    logic [31:0] w_stale_nxt;
    logic        w_ifid_load;
    logic        w_ifid_bubble;
    logic [31:0] w_target;

    logic [31:0] r_ir;
    logic [31:0] r_pc_out;
    logic [31:0] r_next_pc;
    logic        r_valid;

    assign w_target      = {i_branch_target[31:2], 2'b00};
    // In DISCARD the cache is still working on the old miss; keep presenting
    // that address so the request stays stable until it completes.
    assign o_icache_addr = (r_state == DISCARD) ? r_stale_addr : r_pc;
    assign o_icache_req  = ~i_reset;
    assign o_fetch_stall = o_icache_req & ~i_icache_ready;

    assign o_ir      = r_ir;
    assign o_pc_out  = r_pc_out;
    assign o_next_pc = r_next_pc;
    assign o_valid   = r_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_stale_nxt   = r_stale_addr;
        w_ifid_load   = 1'b0;
        w_ifid_bubble = 1'b0;
        case (r_state)
            RUN: begin
                if (i_branch_taken) begin
                    w_pc_nxt      = w_target;
                    w_ifid_bubble = 1'b1;
                    if (!i_icache_ready) begin
                        w_stale_nxt = r_pc;
                        w_state_nxt = DISCARD;
                    end
                end else if (i_stall_pc) begin
                    // hold everything; a returned word is re-requested later
                end else if (i_icache_ready) begin
                    w_ifid_load = 1'b1;
                    w_pc_nxt    = r_pc + 32'd4;
                end else begin
                    w_ifid_bubble = 1'b1;
                end
            end
            DISCARD: begin
                if (i_branch_taken) begin
                    w_pc_nxt      = w_target;
                    w_ifid_bubble = 1'b1;
                end else if (!i_stall_pc) begin
                    w_ifid_bubble = 1'b1;
                end
                // Completion of the stale miss ends discarding; a redirect in
                // the same cycle has already updated pc, which is fetched next.
                if (i_icache_ready) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc         <= RESET_PC;
            r_stale_addr <= 32'h0;
            r_ir         <= NOP_INSTR;
            r_pc_out     <= 32'h0;
            r_next_pc    <= 32'h0;
            r_valid      <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_stale_addr <= w_stale_nxt;
            if (w_ifid_bubble) begin
                r_ir    <= NOP_INSTR;
                r_valid <= 1'b0;
            end else if (w_ifid_load) begin
                r_ir      <= i_icache_data;
                r_pc_out  <= r_pc;
                r_next_pc <= r_pc + 32'd4;
                r_valid   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic [31:0] icache_data;
    logic [31:0] ir;
    logic [31:0] pc_out;
    logic [31:0] next_pc;
    logic        valid;
    logic        fetch_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // cache returns a recognisable word derived from the requested address
    assign icache_data = icache_addr ^ 32'hA5A5_0000;

    fetch_stage dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_stall_pc      (stall_pc),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_icache_req    (icache_req),
        .o_icache_addr   (icache_addr),
        .i_icache_ready  (icache_ready),
        .i_icache_data   (icache_data),
        .o_ir            (ir),
        .o_pc_out        (pc_out),
        .o_next_pc       (next_pc),
        .o_valid         (valid),
        .o_fetch_stall   (fetch_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_ir, input logic [31:0] e_pc,
                            input logic [31:0] e_npc, input logic e_v);
        chk({tag, ".ir"}, ir, e_ir);
        chk({tag, ".pc_out"}, pc_out, e_pc);
        chk({tag, ".next_pc"}, next_pc, e_npc);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_v});
    endtask

    initial begin
        reset = 1'b1; stall_pc = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; icache_ready = 1'b1;
        #2;
        chk("rst.req", {31'd0, icache_req}, 32'd0);
        cyc();
        chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);

        // 1. streaming hits
        reset = 1'b0; #1;
        chk("t1.req", {31'd0, icache_req}, 32'd1);
        chk("t1.addr0", icache_addr, 32'h0000_1000);
        cyc();
        chk_ifid("t1.i0", 32'hA5A5_1000, 32'h1000, 32'h1004, 1'b1);
        chk("t1.addr1", icache_addr, 32'h0000_1004);
        cyc();
        chk_ifid("t1.i1", 32'hA5A5_1004, 32'h1004, 32'h1008, 1'b1);

        // 2. five-cycle miss at 0x1008
        icache_ready = 1'b0; #1;
        chk("t2.fstall", {31'd0, fetch_stall}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2.valid", {31'd0, valid}, 32'd0);
            chk("t2.ir", ir, 32'h0);
            chk("t2.addr", icache_addr, 32'h0000_1008);
            chk("t2.fstall_hold", {31'd0, fetch_stall}, 32'd1);
        end
        icache_ready = 1'b1;
        cyc();
        chk_ifid("t2.hit", 32'hA5A5_1008, 32'h1008, 32'h100C, 1'b1);

        // 3. downstream stall with pc_out=0x100C
        cyc();
        chk_ifid("t3.pre", 32'hA5A5_100C, 32'h100C, 32'h1010, 1'b1);
        stall_pc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_ifid("t3.frozen", 32'hA5A5_100C, 32'h100C, 32'h1010, 1'b1);
            chk("t3.addr", icache_addr, 32'h0000_1010);
        end
        stall_pc = 1'b0;
        cyc();
        chk_ifid("t3.after", 32'hA5A5_1010, 32'h1010, 32'h1014, 1'b1);

        // 4. branch on a hit, unaligned target
        branch_taken = 1'b1; branch_target = 32'h0000_2002;
        cyc();
        branch_taken = 1'b0;
        chk("t4.valid", {31'd0, valid}, 32'd0);
        chk("t4.ir", ir, 32'h0);
        chk("t4.addr", icache_addr, 32'h0000_2000);
        cyc();
        chk_ifid("t4.tgt", 32'hA5A5_2000, 32'h2000, 32'h2004, 1'b1);

        // 5. branch during a miss at 0x1010
        branch_taken = 1'b1; branch_target = 32'h0000_1010;
        cyc();
        branch_taken = 1'b0;
        icache_ready = 1'b0; #1;
        chk("t5.addr_miss", icache_addr, 32'h0000_1010);
        branch_taken = 1'b1; branch_target = 32'h0000_2000;
        cyc();
        branch_taken = 1'b0;
        chk("t5.disc.valid", {31'd0, valid}, 32'd0);
        chk("t5.disc.addr", icache_addr, 32'h0000_1010);
        cyc();
        chk("t5.disc.addr2", icache_addr, 32'h0000_1010);
        chk("t5.disc.fstall", {31'd0, fetch_stall}, 32'd1);
        icache_ready = 1'b1;
        cyc();
        chk("t5.drop.valid", {31'd0, valid}, 32'd0);
        chk("t5.drop.ir", ir, 32'h0);
        chk("t5.next_addr", icache_addr, 32'h0000_2000);
        cyc();
        chk_ifid("t5.tgt", 32'hA5A5_2000, 32'h2000, 32'h2004, 1'b1);

        // 6a. branch with stall: flush wins
        branch_taken = 1'b1; branch_target = 32'h0000_3000; stall_pc = 1'b1;
        cyc();
        branch_taken = 1'b0; stall_pc = 1'b0;
        chk("t6a.valid", {31'd0, valid}, 32'd0);
        chk("t6a.addr", icache_addr, 32'h0000_3000);
        cyc();
        chk_ifid("t6a.tgt", 32'hA5A5_3000, 32'h3000, 32'h3004, 1'b1);

        // 6b. PC wrap-around
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        cyc();
        branch_taken = 1'b0;
        cyc();
        chk_ifid("t6b.wrap", 32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
        chk("t6b.addr", icache_addr, 32'h0000_0000);

        // 6c. reset during a miss
        icache_ready = 1'b0;
        cyc();
        chk("t6c.miss.valid", {31'd0, valid}, 32'd0);
        reset = 1'b1; #1;
        chk("t6c.req_low", {31'd0, icache_req}, 32'd0);
        cyc();
        reset = 1'b0; #1;
        chk("t6c.req_high", {31'd0, icache_req}, 32'd1);
        chk("t6c.addr", icache_addr, 32'h0000_1000);
        chk("t6c.valid", {31'd0, valid}, 32'd0);
        icache_ready = 1'b1;
        cyc();
        chk_ifid("t6c.first", 32'hA5A5_1000, 32'h1000, 32'h1004, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
